ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single-port program/data RAM between three masters: the UART receive loader (rx), the UART transmit dumper (tx) and the CPU. Each master holds a request until it gets a one-cycle grant. The arbiter sequences exactly one RAM access per grant and returns read data with a valid strobe. It sits between the IO sequencer, the CPU memory port and the RAM. It replaces the ad-hoc `sel`-driven address mux.

## Interface
Parameters:
- `ADDR_W`, 16: RAM address width (65536 words).
- `DATA_W`, 8: RAM data width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `cpu_en`  in  1: 1 means CPU requests are eligible; 0 masks the CPU (IO owns RAM).
- `rx_req`, `tx_req`, `cpu_req`  in  1 each: access request, held until the matching grant.
- `rx_we`, `tx_we`, `cpu_we`  in  1 each: 1 = write, 0 = read; stable while req is high.
- `rx_addr`, `tx_addr`, `cpu_addr`  in  ADDR_W each: access address.
- `rx_wdata`, `tx_wdata`, `cpu_wdata`  in  DATA_W each: write data.
- `rx_gnt`, `tx_gnt`, `cpu_gnt`  out  1 each: one-cycle grant pulse.
- `rx_rvalid`, `tx_rvalid`, `cpu_rvalid`  out  1 each: one-cycle read-data-valid pulse.
- `rdata`  out  DATA_W: read data, shared by all masters (direct from `ram_dout`).
- `ram_addr`  out  ADDR_W: registered RAM address.
- `ram_we`  out  1: registered RAM write enable.
- `ram_din`  out  DATA_W: registered RAM write data.
- `ram_dout`  in  DATA_W: RAM read data, one clock after the address.

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- **IDLE:**
  - Evaluate eligible requests (`cpu_req` is eligible only when `cpu_en` is 1).
  - If any request is eligible, pick a winner, register its addr, we and wdata onto the RAM port, and go to ACCESS.
  - Otherwise stay in IDLE with `ram_we` at 0.
- **ACCESS:**
  - Winner's gnt is 1 for this cycle only.
  - `ram_we` is 1 for a write.
  - Next state: IDLE for a write, RDATA for a read.
- **RDATA:**
  - Winner's rvalid is 1 for this cycle; `rdata` is valid.
  - Next state: IDLE.
- **Arbitration, default (fixed priority):** rx > tx > cpu.
- **Master obligations:**
  - Drop req in the cycle after gnt. A req still high when the arbiter returns to IDLE is treated as a new access.
  - Hold addr, we and wdata from req until gnt.
- **`cpu_en` changes:**
  - A fall during the CPU's ACCESS or RDATA does not abort; that access completes.
  - A fall in IDLE takes effect the same cycle.
- **Simultaneous requests:** exactly one grant per arbitration. Losers keep waiting with no grant and no side effects.
- **Reset values:**
  - All gnt and rvalid outputs at 0.
  - `ram_we` at 0, `ram_addr` at 0, `ram_din` at 0.
  - State at IDLE; round-robin pointer at rx.
- **Reset mid-access:** the access is abandoned. `ram_we` is 0 in the cycle after reset is sampled, and no gnt or rvalid is issued for it.
- **Address:** no wrap or bounds logic; the full ADDR_W range is passed through.

## Timing
- Request sampled at edge N in IDLE → RAM port driven and gnt asserted in cycle N+1.
- Write committed at edge N+2.
- Read: `rdata` and rvalid in cycle N+2.
- Minimum spacing between accesses: 2 cycles per write, 3 cycles per read. IDLE always lasts at least one cycle between accesses.
- Worst-case wait under fixed priority is unbounded for cpu and tx. With the round-robin macro, the wait is bounded by 2 other accesses.

## Configuration
- Macro: `RAM_ARB_ROUND_ROBIN_EN`.
- **Defined:** rotating priority. After each grant, the granted master becomes lowest priority; the order otherwise cycles rx → tx → cpu. The pointer is reset to rx (rx highest).
- **Undefined:** fixed priority rx > tx > cpu. No pointer register exists.

## Structure
- Shared package `ram_arb_pkg`:
  - state encoding (IDLE, ACCESS, RDATA);
  - master index constants (`M_RX`=0, `M_TX`=1, `M_CPU`=2);
  - default `ADDR_W` and `DATA_W`.
- One sub-module, `ram_arb_pick`. It is purely combinational: it takes the eligible request vector and the priority pointer and returns a one-hot winner. The fixed-priority and round-robin versions are selected there by the macro.
- FSM, registers and the RAM port mux stay in `ram_port_arbiter`.

## Test plan
- **Reset and write:** reset, then `rx_req`=1, `rx_we`=1, `rx_addr`=0x0010, `rx_wdata`=0xA5 → `rx_gnt` one cycle later, `ram_we`=1 with `ram_addr`=0x0010 and `ram_din`=0xA5 for exactly 1 cycle.
- **Read latency:** RAM preloaded with 0x3C at 0x0010; `tx_req` read at 0x0010 → `tx_gnt` at N+1, `tx_rvalid`=1 and `rdata`=0x3C at N+2, no other rvalid.
- **Simultaneous requests, fixed priority:** rx, tx and cpu (`cpu_en`=1) all request in the same cycle → grant order rx, tx, cpu, with one access at a time and 2–3 cycle spacing.
- **Round-robin (macro defined):** all three masters re-requesting continuously for 9 grants → sequence rx, tx, cpu ×3.
- **CPU masking:** `cpu_en`=0 with `cpu_req` held → no `cpu_gnt` for 20 cycles. Raising `cpu_en` → `cpu_gnt` 1 cycle later.
- **Reset mid-read:** `reset` pulsed during ACCESS of a cpu read → no `cpu_rvalid`, `ram_we`=0, state returns to IDLE, and a fresh request is served normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, master
// indices, default bus widths and small master-index helpers.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int N_MASTERS  = 3;

  typedef logic [1:0] master_t;

  localparam master_t M_RX  = 2'd0;
  localparam master_t M_TX  = 2'd1;
  localparam master_t M_CPU = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  // Rotation order rx -> tx -> cpu -> rx.
  function automatic master_t next_master(master_t m);
    return (m == M_CPU) ? M_RX : m + 2'd1;
  endfunction

  function automatic master_t onehot_idx(logic [N_MASTERS-1:0] oh);
    if (oh[M_TX])  return M_TX;
    if (oh[M_CPU]) return M_CPU;
    return M_RX;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection over the eligible request vector.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects rotating priority from ptr.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  master_t              ptr,
`endif
  output logic [N_MASTERS-1:0] winner
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  master_t idx;
  logic    found;

  // Walk the rotation starting at ptr; the first requester found wins.
  always_comb begin
    winner = '0;
    idx    = ptr;
    found  = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
      idx = next_master(idx);
    end
  end
`else
  always_comb begin
    winner        = '0;
    winner[M_RX]  = req[M_RX];
    winner[M_TX]  = req[M_TX] & ~req[M_RX];
    winner[M_CPU] = req[M_CPU] & ~req[M_TX] & ~req[M_RX];
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter for the rx loader, tx dumper and CPU: one access per
// grant, registered RAM port. Build option: RAM_ARB_ROUND_ROBIN_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              rx_req,
  input  logic              tx_req,
  input  logic              cpu_req,
  input  logic              rx_we,
  input  logic              tx_we,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] rx_wdata,
  input  logic [DATA_W-1:0] tx_wdata,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rx_gnt,
  output logic              tx_gnt,
  output logic              cpu_gnt,
  output logic              rx_rvalid,
  output logic              tx_rvalid,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t                state, state_nxt;
  logic [N_MASTERS-1:0]  eligible, pick, win_q;
  logic                  load;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_we;

  // A masked CPU is simply not eligible, so cpu_en acts within the same cycle.
  assign eligible = {cpu_req & cpu_en, tx_req, rx_req};
  assign rdata    = ram_dout;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  master_t ptr;

  ram_arb_pick u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .winner (pick)
  );
`else
  ram_arb_pick u_pick (
    .req    (eligible),
    .winner (pick)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    rx_gnt     = 1'b0;
    tx_gnt     = 1'b0;
    cpu_gnt    = 1'b0;
    rx_rvalid  = 1'b0;
    tx_rvalid  = 1'b0;
    cpu_rvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          load      = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rx_gnt    = win_q[M_RX];
        tx_gnt    = win_q[M_TX];
        cpu_gnt   = win_q[M_CPU];
        state_nxt = ram_we ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        rx_rvalid  = win_q[M_RX];
        tx_rvalid  = win_q[M_TX];
        cpu_rvalid = win_q[M_CPU];
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = rx_addr;
    sel_wdata = rx_wdata;
    sel_we    = rx_we;
    if (pick[M_TX]) begin
      sel_addr  = tx_addr;
      sel_wdata = tx_wdata;
      sel_we    = tx_we;
    end else if (pick[M_CPU]) begin
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      sel_we    = cpu_we;
    end
  end

  // ram_we is a single-cycle pulse: it defaults low and is set only on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      win_q    <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr      <= M_RX;
`endif
    end else begin
      ram_we <= 1'b0;
      if (load) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
        ram_we   <= sel_we;
        win_q    <= pick;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        ptr      <= next_master(onehot_idx(pick));
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a one-cycle-latency
// RAM model; expectations follow RAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk, reset, cpu_en;
  logic              rx_req, tx_req, cpu_req;
  logic              rx_we, tx_we, cpu_we;
  logic [ADDR_W-1:0] rx_addr, tx_addr, cpu_addr;
  logic [DATA_W-1:0] rx_wdata, tx_wdata, cpu_wdata;
  logic              rx_gnt, tx_gnt, cpu_gnt;
  logic              rx_rvalid, tx_rvalid, cpu_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din, ram_dout;

  logic [DATA_W-1:0] mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;
  int gm [0:15];
  int gc [0:15];
  int ng;
  int multi;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .rx_req     (rx_req),
    .tx_req     (tx_req),
    .cpu_req    (cpu_req),
    .rx_we      (rx_we),
    .tx_we      (tx_we),
    .cpu_we     (cpu_we),
    .rx_addr    (rx_addr),
    .tx_addr    (tx_addr),
    .cpu_addr   (cpu_addr),
    .rx_wdata   (rx_wdata),
    .tx_wdata   (tx_wdata),
    .cpu_wdata  (cpu_wdata),
    .rx_gnt     (rx_gnt),
    .tx_gnt     (tx_gnt),
    .cpu_gnt    (cpu_gnt),
    .rx_rvalid  (rx_rvalid),
    .tx_rvalid  (tx_rvalid),
    .cpu_rvalid (cpu_rvalid),
    .rdata      (rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model, read-before-write, one clock read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch grants for up to budget cycles; optionally drop a master's req once granted.
  task automatic collect_grants(input int n, input int budget, input bit drop_on_gnt);
    ng    = 0;
    multi = 0;
    for (int c = 1; c <= budget && ng < n; c++) begin
      tick();
      if (32'(rx_gnt) + 32'(tx_gnt) + 32'(cpu_gnt) > 1) multi++;
      if (rx_gnt) begin
        gm[ng] = 0; gc[ng] = c; ng++;
        if (drop_on_gnt) rx_req = 1'b0;
      end else if (tx_gnt) begin
        gm[ng] = 1; gc[ng] = c; ng++;
        if (drop_on_gnt) tx_req = 1'b0;
      end else if (cpu_gnt) begin
        gm[ng] = 2; gc[ng] = c; ng++;
        if (drop_on_gnt) cpu_req = 1'b0;
      end
    end
    check("grant count", ng, n);
    check("one grant at a time", multi, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int exp_m;
  int gnt_seen;
  int we_seen;

  initial begin
    reset   = 1'b1;
    cpu_en  = 1'b0;
    rx_req  = 1'b0; tx_req  = 1'b0; cpu_req  = 1'b0;
    rx_we   = 1'b0; tx_we   = 1'b0; cpu_we   = 1'b0;
    rx_addr = '0;   tx_addr = '0;   cpu_addr = '0;
    rx_wdata = '0;  tx_wdata = '0;  cpu_wdata = '0;

    // Reset state
    tick();
    tick();
    check("reset gnt", {rx_gnt, tx_gnt, cpu_gnt}, 3'b000);
    check("reset rvalid", {rx_rvalid, tx_rvalid, cpu_rvalid}, 3'b000);
    check("reset ram_we", ram_we, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_din", ram_din, 0);
    reset = 1'b0;
    tick();

    // rx write 0xA5 to 0x0010
    rx_req = 1'b1; rx_we = 1'b1; rx_addr = 16'h0010; rx_wdata = 8'hA5;
    tick();
    check("wr rx_gnt", rx_gnt, 1);
    check("wr ram_we", ram_we, 1);
    check("wr ram_addr", ram_addr, 16'h0010);
    check("wr ram_din", ram_din, 8'hA5);
    rx_req = 1'b0;
    tick();
    check("wr gnt gone", rx_gnt, 0);
    check("wr ram_we pulse", ram_we, 0);
    check("wr committed", mem[16'h0010], 8'hA5);

    // tx write 0x3C to 0x0010, then tx read back
    tx_req = 1'b1; tx_we = 1'b1; tx_addr = 16'h0010; tx_wdata = 8'h3C;
    tick();
    check("tx wr gnt", tx_gnt, 1);
    tx_req = 1'b0;
    tick();
    tx_req = 1'b1; tx_we = 1'b0;
    tick();
    check("rd tx_gnt", tx_gnt, 1);
    check("rd ram_we", ram_we, 0);
    check("rd ram_addr", ram_addr, 16'h0010);
    tx_req = 1'b0;
    tick();
    check("rd tx_rvalid", tx_rvalid, 1);
    check("rd rdata", rdata, 8'h3C);
    check("rd other rvalid", {rx_rvalid, cpu_rvalid}, 2'b00);
    check("rd gnt gone", tx_gnt, 0);
    tick();
    check("rd rvalid pulse", tx_rvalid, 0);

    // Simultaneous writes from all three masters
    do_reset();
    cpu_en = 1'b1;
    rx_req  = 1'b1; rx_we  = 1'b1; rx_addr  = 16'h0100; rx_wdata  = 8'h11;
    tx_req  = 1'b1; tx_we  = 1'b1; tx_addr  = 16'h0101; tx_wdata  = 8'h22;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0102; cpu_wdata = 8'h33;
    collect_grants(3, 20, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sim order %0d", i), gm[i], i);
      check($sformatf("sim cycle %0d", i), gc[i], 2 * i + 1);
    end
    tick();
    check("sim mem rx", mem[16'h0100], 8'h11);
    check("sim mem tx", mem[16'h0101], 8'h22);
    check("sim mem cpu", mem[16'h0102], 8'h33);

    // Continuous requests for 9 grants
    do_reset();
    rx_req  = 1'b1; rx_we  = 1'b1; rx_addr  = 16'h0200; rx_wdata  = 8'h44;
    tx_req  = 1'b1; tx_we  = 1'b1; tx_addr  = 16'h0201; tx_wdata  = 8'h55;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0202; cpu_wdata = 8'h66;
    collect_grants(9, 40, 1'b0);
    for (int i = 0; i < 9; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_m = i % 3;
`else
      exp_m = 0;
`endif
      check($sformatf("cont order %0d", i), gm[i], exp_m);
      check($sformatf("cont cycle %0d", i), gc[i], 2 * i + 1);
    end
    rx_req = 1'b0; tx_req = 1'b0; cpu_req = 1'b0;
    tick();
    tick();

    // CPU masked with its request held, then unmasked
    cpu_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0102;
    gnt_seen = 0;
    we_seen  = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (cpu_gnt) gnt_seen++;
      if (ram_we) we_seen++;
    end
    check("mask no cpu_gnt", gnt_seen, 0);
    check("mask no ram_we", we_seen, 0);
    cpu_en = 1'b1;
    tick();
    check("unmask cpu_gnt", cpu_gnt, 1);
    check("unmask ram_addr", ram_addr, 16'h0102);
    cpu_req = 1'b0;
    tick();
    check("unmask cpu_rvalid", cpu_rvalid, 1);
    check("unmask rdata", rdata, 8'h33);
    check("unmask other rvalid", {rx_rvalid, tx_rvalid}, 2'b00);
    tick();

    // Reset during a CPU read access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    tick();
    check("rst cpu_gnt", cpu_gnt, 1);
    reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    check("rst no rvalid", cpu_rvalid, 0);
    check("rst ram_we", ram_we, 0);
    check("rst no gnt", {rx_gnt, tx_gnt, cpu_gnt}, 3'b000);
    reset = 1'b0;
    tick();
    check("post rst no rvalid", cpu_rvalid, 0);
    check("post rst no gnt", cpu_gnt, 0);
    cpu_req = 1'b1;
    tick();
    check("fresh cpu_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick();
    check("fresh cpu_rvalid", cpu_rvalid, 1);
    check("fresh rdata", rdata, 8'h3C);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
